// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter
//  Serialises parallel bytes from the display command sequencer onto an SPI
//  MOSI line, MSB first. Bit timing comes from one-clk strobes produced by an
//  external serial clock generator. The block drives the panel chip-select
//  (active-low) and the data/command line. It hands bytes back and forth with
//  the sequencer through a ready/byteDone handshake.
//
//  Build option:
//   SPI_TX_SKID_EN  when defined, a one-entry holding buffer lets the next
//                   byte be accepted while the current one shifts. Consecutive
//                   bytes then stream with no chip-select gap. When undefined,
//                   bytes are only accepted while idle.
//
//  Ports:
//   clk          in   system clock, all state on posedge
//   reset        in   asynchronous, active-high reset
//   sclkNegEdge  in   one-clk strobe: serial clock falling edge (mosi/csOut change)
//   sclkPosEdge  in   one-clk strobe: serial clock rising edge (slave samples)
//   pcEn         in   parallel-load request; accepted when pcEn && ready
//   parallelData in   byte to send
//   dcIn         in   1 = data, 0 = command; captured with the byte
//   ready        out  block accepts a byte this clk
//   busy         out  a byte is loaded or being shifted
//   byteDone     out  one-clk pulse after the last bit has been held a full sclk
//   mosi         out  serial data, MSB first
//   dcOut        out  data/command flag for the byte on the wire
//   csOut        out  panel chip-select, active-low

module spi_tx_shifter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclkNegEdge,
    input  logic                  sclkPosEdge,
    input  logic                  pcEn,
    input  logic [DATA_WIDTH-1:0] parallelData,
    input  logic                  dcIn,
    output logic                  ready,
    output logic                  busy,
    output logic                  byteDone,
    output logic                  mosi,
    output logic                  dcOut,
    output logic                  csOut
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_INDEX = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shiftReg;
    logic [CW-1:0]         bitCount;
    logic                  accept;
    logic                  negStrobe;
    logic                  lastBitEnd;

    // The rising-edge strobe never moves state. When both strobes are high
    // together, the falling-edge rules win, so only sclkNegEdge matters here.
    assign negStrobe  = sclkNegEdge | (sclkNegEdge & sclkPosEdge);
    assign accept     = pcEn & ready;
    assign lastBitEnd = negStrobe && (state == SHIFT) && (bitCount == '0);

`ifdef SPI_TX_SKID_EN
    logic [DATA_WIDTH-1:0] skidData;
    logic                  skidDc;
    logic                  skidValid;
    logic [DATA_WIDTH-1:0] nextData;
    logic                  nextDc;

    // At the end of a byte, the follow-on byte comes from the skid entry if one
    // is waiting. Otherwise it comes straight from the producer if it is being
    // accepted on that very clk.
    assign nextData = skidValid ? skidData : parallelData;
    assign nextDc   = skidValid ? skidDc   : dcIn;
`endif

    // Transmit FSM. IDLE waits for a byte. LOAD waits for the first falling
    // sclk edge, so a byte accepted on a strobe clk does not use that strobe.
    // SHIFT moves one bit per falling edge. All outputs are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shiftReg <= '0;
            bitCount <= '0;
            mosi     <= 1'b0;
            dcOut    <= 1'b0;
            csOut    <= 1'b1;
            busy     <= 1'b0;
            byteDone <= 1'b0;
            ready    <= 1'b1;
`ifdef SPI_TX_SKID_EN
            skidData  <= '0;
            skidDc    <= 1'b0;
            skidValid <= 1'b0;
`endif
        end else begin
            byteDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shiftReg <= parallelData;
                        dcOut    <= dcIn;
                        busy     <= 1'b1;
`ifndef SPI_TX_SKID_EN
                        ready    <= 1'b0;
`endif
                        state    <= LOAD;
                    end
                end

                LOAD: begin
                    if (negStrobe) begin
                        // Chip-select falls together with the MSB. This gives
                        // half an sclk of setup before the first sample.
                        csOut    <= 1'b0;
                        mosi     <= shiftReg[DATA_WIDTH-1];
                        bitCount <= LAST_INDEX;
                        state    <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (negStrobe && bitCount != '0) begin
                        shiftReg <= {shiftReg[DATA_WIDTH-2:0], 1'b0};
                        mosi     <= shiftReg[DATA_WIDTH-2];
                        bitCount <= bitCount - 1'b1;
                    end else if (negStrobe) begin
                        byteDone <= 1'b1;
`ifdef SPI_TX_SKID_EN
                        if (skidValid || accept) begin
                            // Chain straight into the next byte. Chip-select
                            // stays low, so the bit stream is contiguous.
                            shiftReg  <= nextData;
                            dcOut     <= nextDc;
                            mosi      <= nextData[DATA_WIDTH-1];
                            bitCount  <= LAST_INDEX;
                            skidValid <= 1'b0;
                            ready     <= 1'b1;
                        end else
`endif
                        begin
                            csOut <= 1'b1;
                            mosi  <= 1'b0;
                            busy  <= 1'b0;
                            ready <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase

`ifdef SPI_TX_SKID_EN
            // A byte offered while busy is parked in the skid entry. At the
            // byte-ending strobe, the chaining branch above consumes it instead.
            if (accept && state != IDLE && !lastBitEnd) begin
                skidData  <= parallelData;
                skidDc    <= dcIn;
                skidValid <= 1'b1;
                ready     <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_spi_tx_shifter.sv
// tb_spi_tx_shifter
//  Directed bench for spi_tx_shifter with DATA_WIDTH = 8. A free-running
//  strobe generator produces sclkNegEdge and sclkPosEdge every 8 clks, with
//  the two strobes 4 clks apart. mosi is sampled at every sclkPosEdge while
//  chip-select is low.

module tb_spi_tx_shifter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclkNegEdge = 1'b0;
    logic       sclkPosEdge = 1'b0;
    logic       pcEn = 1'b0;
    logic [7:0] parallelData = 8'h00;
    logic       dcIn = 1'b0;
    logic       ready, busy, byteDone, mosi, dcOut, csOut;

    int checks = 0;
    int passes = 0;
    int phase  = 0;

    spi_tx_shifter #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .sclkNegEdge  (sclkNegEdge),
        .sclkPosEdge  (sclkPosEdge),
        .pcEn         (pcEn),
        .parallelData (parallelData),
        .dcIn         (dcIn),
        .ready        (ready),
        .busy         (busy),
        .byteDone     (byteDone),
        .mosi         (mosi),
        .dcOut        (dcOut),
        .csOut        (csOut)
    );

    always #5 clk = ~clk;

    // Serial clock: period of 8 clks. The falling strobe is at phase 0 and the
    // rising strobe at phase 4. Strobes are driven on the clk falling edge so
    // they are stable through each rising edge.
    always @(negedge clk) begin
        phase       = (phase == 7) ? 0 : phase + 1;
        sclkNegEdge = (phase == 0);
        sclkPosEdge = (phase == 4);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offers a byte until it is taken. Returns just after the accepting edge.
    task automatic acceptByte(input logic [7:0] d, input logic dc, output bit ok);
        int  t;
        bit  wasReady;
        ok = 0;
        t  = 0;
        @(negedge clk);
        parallelData = d;
        dcIn         = dc;
        pcEn         = 1'b1;
        while (!ok && t < 200) begin
            wasReady = ready;
            tick;
            if (wasReady) ok = 1;
            else @(negedge clk);
            t++;
        end
        pcEn = 1'b0;
    endtask

    // Waits for chip-select to fall and captures 8 samples. Then waits for
    // byteDone and returns on the tick where it is seen.
    task automatic captureByte(output logic [7:0] bits, output bit csLowAll,
                               output logic dcFirst, output bit dcStable,
                               output bit readySeen, output int csGap, output bit ok);
        int t;
        int n;
        bits = '0; csLowAll = 1; dcFirst = 1'b0; dcStable = 1;
        readySeen = 0; csGap = 0; ok = 0; n = 0; t = 0;
        tick;
        while (csOut && t < 100) begin
            csGap++;
            tick;
            t++;
        end
        while (n < 8 && t < 300) begin
            tick;
            t++;
            if (ready) readySeen = 1;
            if (sclkPosEdge) begin
                bits = {bits[6:0], mosi};
                if (csOut !== 1'b0) csLowAll = 0;
                if (n == 0) dcFirst = dcOut;
                else if (dcOut !== dcFirst) dcStable = 0;
                n++;
            end
        end
        while (!byteDone && t < 300) begin
            tick;
            t++;
        end
        ok = (byteDone === 1'b1) && (n == 8);
    endtask

    task automatic test_reset;
        repeat (3) tick;
        checks++; if (csOut !== 1'b1)    $display("[TB] FAIL reset_cs: got %b expected 1", csOut);    else passes++;
        checks++; if (mosi !== 1'b0)     $display("[TB] FAIL reset_mosi: got %b expected 0", mosi);   else passes++;
        checks++; if (busy !== 1'b0)     $display("[TB] FAIL reset_busy: got %b expected 0", busy);   else passes++;
        checks++; if (ready !== 1'b1)    $display("[TB] FAIL reset_ready: got %b expected 1", ready); else passes++;
        checks++; if (byteDone !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", byteDone); else passes++;
        checks++; if (dcOut !== 1'b0)    $display("[TB] FAIL reset_dc: got %b expected 0", dcOut);    else passes++;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) tick;
        checks++; if (csOut !== 1'b1 || ready !== 1'b1) $display("[TB] FAIL idle_after_reset: cs=%b ready=%b expected 1/1", csOut, ready); else passes++;
    endtask

    task automatic test_byte_a5;
        bit ok, csLow, dcSt, rdy;
        logic [7:0] bits;
        logic dcF;
        int gap, extra;
        acceptByte(8'hA5, 1'b1, ok);
        checks++; if (!ok) $display("[TB] FAIL a5_accept: got not accepted expected accepted"); else passes++;
        captureByte(bits, csLow, dcF, dcSt, rdy, gap, ok);
        checks++; if (bits !== 8'hA5) $display("[TB] FAIL a5_bits: got %h expected a5", bits); else passes++;
        checks++; if (!csLow) $display("[TB] FAIL a5_cs_low: got cs high during a sample expected low"); else passes++;
        checks++; if (dcF !== 1'b1 || !dcSt) $display("[TB] FAIL a5_dc: got %b stable=%0d expected 1 stable", dcF, dcSt); else passes++;
        checks++; if (!ok) $display("[TB] FAIL a5_done: got no byteDone expected pulse"); else passes++;
        checks++; if (csOut !== 1'b1 || mosi !== 1'b0 || ready !== 1'b1)
            $display("[TB] FAIL a5_end: got cs=%b mosi=%b ready=%b expected 1/0/1", csOut, mosi, ready); else passes++;
        extra = 0;
        repeat (20) begin tick; if (byteDone) extra++; end
        checks++; if (extra != 0) $display("[TB] FAIL a5_single_done: got %0d extra pulses expected 0", extra); else passes++;
    endtask

    task automatic test_byte_33;
        bit ok, csLow, dcSt, rdy;
        logic [7:0] bits;
        logic dcF;
        int gap;
        acceptByte(8'h33, 1'b0, ok);
        captureByte(bits, csLow, dcF, dcSt, rdy, gap, ok);
        checks++; if (bits !== 8'h33) $display("[TB] FAIL b33_bits: got %h expected 33", bits); else passes++;
        checks++; if (dcF !== 1'b0 || !dcSt) $display("[TB] FAIL b33_dc: got %b stable=%0d expected 0 stable", dcF, dcSt); else passes++;
        checks++; if (!ok || !csLow) $display("[TB] FAIL b33_frame: got done=%0d csLow=%0d expected 1/1", ok, csLow); else passes++;
        repeat (4) tick;
    endtask

    task automatic test_ignore_while_busy;
        bit ok, csLow, dcSt, rdy;
        logic [7:0] bits;
        logic dcF;
        int gap, totalGap;
        acceptByte(8'hA5, 1'b1, ok);
        // Hold the next byte on the inputs for the whole of the first one.
        pcEn = 1'b1; parallelData = 8'hFF; dcIn = 1'b0;
        captureByte(bits, csLow, dcF, dcSt, rdy, gap, ok);
        checks++; if (rdy) $display("[TB] FAIL hold_ready: got ready=1 while busy expected 0"); else passes++;
        checks++; if (bits !== 8'hA5 || dcF !== 1'b1 || !dcSt)
            $display("[TB] FAIL hold_first_byte: got %h dc=%b expected a5 dc=1", bits, dcF); else passes++;
        totalGap = (csOut === 1'b1) ? 1 : 0;
        tick;
        checks++; if (busy !== 1'b1) $display("[TB] FAIL hold_accept_idle: got busy=%b expected 1", busy); else passes++;
        pcEn = 1'b0;
        if (csOut === 1'b1) totalGap++;
        captureByte(bits, csLow, dcF, dcSt, rdy, gap, ok);
        totalGap += gap;
        checks++; if (totalGap < 8) $display("[TB] FAIL hold_cs_gap: got %0d clks expected >= 8", totalGap); else passes++;
        checks++; if (bits !== 8'hFF || dcF !== 1'b0 || !ok)
            $display("[TB] FAIL hold_second_byte: got %h dc=%b done=%0d expected ff dc=0 done=1", bits, dcF, ok); else passes++;
        repeat (4) tick;
    endtask

    task automatic test_skid_back_to_back;
        bit ok1, ok2, csLowAll, dcBad;
        logic [15:0] bits16;
        int t, n, doneCount, firstDone, secondDone, tickNo;
        acceptByte(8'h0F, 1'b1, ok1);
        acceptByte(8'hF0, 1'b0, ok2);
        checks++; if (!ok1 || !ok2) $display("[TB] FAIL skid_accept: got %0d/%0d expected 1/1", ok1, ok2); else passes++;
        checks++; if (ready !== 1'b0) $display("[TB] FAIL skid_full_ready: got %b expected 0", ready); else passes++;
        t = 0;
        while (csOut && t < 100) begin tick; t++; end
        bits16 = '0; n = 0; csLowAll = 1; dcBad = 0;
        doneCount = 0; firstDone = 0; secondDone = 0; tickNo = 0;
        while ((n < 16 || doneCount < 2) && t < 400) begin
            tick; t++; tickNo++;
            if (byteDone) begin
                doneCount++;
                if (doneCount == 1) firstDone = tickNo;
                else if (doneCount == 2) secondDone = tickNo;
            end
            if (sclkPosEdge && n < 16) begin
                bits16 = {bits16[14:0], mosi};
                if (csOut !== 1'b0) csLowAll = 0;
                if (dcOut !== logic'(n < 8)) dcBad = 1;
                n++;
            end
        end
        checks++; if (bits16 !== 16'h0FF0) $display("[TB] FAIL skid_bits: got %h expected 0ff0", bits16); else passes++;
        checks++; if (!csLowAll) $display("[TB] FAIL skid_cs: got cs high between bytes expected low"); else passes++;
        checks++; if (dcBad) $display("[TB] FAIL skid_dc: got wrong dc on some bit expected 1 then 0 from bit 9"); else passes++;
        checks++; if (doneCount != 2) $display("[TB] FAIL skid_done_count: got %0d expected 2", doneCount); else passes++;
        checks++; if (secondDone - firstDone != 64) $display("[TB] FAIL skid_done_spacing: got %0d clks expected 64", secondDone - firstDone); else passes++;
        checks++; if (csOut !== 1'b1 || ready !== 1'b1) $display("[TB] FAIL skid_end: got cs=%b ready=%b expected 1/1", csOut, ready); else passes++;
        repeat (4) tick;
    endtask

    task automatic test_reset_mid_byte;
        bit ok, csLow, dcSt, rdy;
        logic [7:0] bits;
        logic dcF;
        int t, n, gap, dones;
        acceptByte(8'hA5, 1'b1, ok);
        t = 0; n = 0;
        while (csOut && t < 100) begin tick; t++; end
        while (n < 3 && t < 200) begin
            tick; t++;
            if (sclkPosEdge) n++;
        end
        #2 reset = 1'b1;
        #1;
        checks++; if (csOut !== 1'b1 || mosi !== 1'b0) $display("[TB] FAIL rst_mid_lines: got cs=%b mosi=%b expected 1/0", csOut, mosi); else passes++;
        checks++; if (busy !== 1'b0 || ready !== 1'b1) $display("[TB] FAIL rst_mid_hs: got busy=%b ready=%b expected 0/1", busy, ready); else passes++;
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (80) begin tick; if (byteDone) dones++; end
        checks++; if (dones != 0) $display("[TB] FAIL rst_mid_no_done: got %0d pulses expected 0", dones); else passes++;
        acceptByte(8'h5A, 1'b0, ok);
        captureByte(bits, csLow, dcF, dcSt, rdy, gap, ok);
        checks++; if (bits !== 8'h5A || !ok || !csLow) $display("[TB] FAIL rst_mid_next: got %h done=%0d expected 5a done=1", bits, ok); else passes++;
        repeat (4) tick;
    endtask

    task automatic test_coincident_accept;
        bit ok, csLow, dcSt, rdy;
        logic [7:0] bits;
        logic dcF;
        int t, gap;
        t = 0;
        tick;
        while (!sclkNegEdge && t < 20) begin tick; t++; end
        repeat (7) tick;
        pcEn = 1'b1; parallelData = 8'hC3; dcIn = 1'b1;
        tick;
        pcEn = 1'b0;
        if (!sclkNegEdge) $display("[TB] note: strobe alignment lost");
        checks++; if (busy !== 1'b1) $display("[TB] FAIL coin_accept: got busy=%b expected 1", busy); else passes++;
        checks++; if (csOut !== 1'b1 || mosi !== 1'b0) $display("[TB] FAIL coin_no_bit: got cs=%b mosi=%b expected 1/0", csOut, mosi); else passes++;
        captureByte(bits, csLow, dcF, dcSt, rdy, gap, ok);
        checks++; if (gap != 7) $display("[TB] FAIL coin_first_bit_delay: got %0d clks expected 7", gap); else passes++;
        checks++; if (bits !== 8'hC3 || !ok || dcF !== 1'b1) $display("[TB] FAIL coin_bits: got %h dc=%b expected c3 dc=1", bits, dcF); else passes++;
        repeat (4) tick;
    endtask

    initial begin
        test_reset;
        test_byte_a5;
        test_byte_33;
`ifdef SPI_TX_SKID_EN
        test_skid_back_to_back;
`else
        test_ignore_while_busy;
`endif
        test_reset_mid_byte;
        test_coincident_accept;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
